// File: rtl/delay_line_ctrl_pkg.sv
// rtl/delay_line_ctrl_pkg.sv - shared state encoding for the delay-line sequencer
package delay_line_ctrl_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/delay_line_ctrl_ptr.sv
// rtl/delay_line_ctrl_ptr.sv - wrapping address counter with clear and enable
// Ports: clk, rst (sync, active-high), clr (force 0), en (advance),
//        cnt (current value), cnt_inc (cnt + 1 modulo 2**A_WIDTH)
module delay_ptr #(
    parameter int A_WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [A_WIDTH-1:0] cnt,
    output logic [A_WIDTH-1:0] cnt_inc
);

    // Natural overflow of the A_WIDTH-bit add gives the modulo wrap.
    assign cnt_inc = cnt + A_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// rtl/delay_line_ctrl.sv - address/enable sequencer for the signal-delay RAM datapath
// Ports: clk, rst (sync, active-high); start/stop pulses; sample_en strobe;
//        cfg_valid/cfg_delay/cfg_ready delay-update handshake;
//        wr_enable/wr_addr/wr_zero and rd_enable/rd_addr drive the dual-port RAM;
//        out_valid flags valid RAM dout; busy and state_o report the sequencer state.
module delay_line_ctrl
    import delay_line_ctrl_pkg::*;
#(
    parameter int A_WIDTH       = 9,
    parameter int D_WIDTH       = 8,
    parameter int DEFAULT_DELAY = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               sample_en,
    input  logic               cfg_valid,
    input  logic [A_WIDTH-1:0] cfg_delay,
    output logic               cfg_ready,
    output logic               wr_enable,
    output logic [A_WIDTH-1:0] wr_addr,
    output logic               wr_zero,
    output logic               rd_enable,
    output logic [A_WIDTH-1:0] rd_addr,
    output logic               out_valid,
    output logic               busy,
    output logic [ST_W-1:0]    state_o
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [A_WIDTH-1:0] RST_DELAY = A_WIDTH'(DEFAULT_DELAY);

    // The sample path lives in the datapath; D_WIDTH only has to be sane.
    if (D_WIDTH < 1 || DEFAULT_DELAY < 1 || DEFAULT_DELAY >= (2 ** A_WIDTH)) begin : g_param_check
        $error("delay_line_ctrl: bad D_WIDTH or DEFAULT_DELAY for this A_WIDTH");
    end

    state_t             state;
    state_t             state_n;
    logic [A_WIDTH-1:0] ptr;
    logic [A_WIDTH-1:0] ptr_inc;
    logic               ptr_clr;
    logic               ptr_en;
    logic [A_WIDTH-1:0] fill_cnt;
    logic [A_WIDTH-1:0] fill_inc;
    logic [A_WIDTH-1:0] delay_q;
    logic [A_WIDTH-1:0] cfg_delay_eff;
    logic               cfg_xfer;

    // Shared between the CLEAR sweep and the sample write pointer.
    delay_ptr #(
        .A_WIDTH (A_WIDTH)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .clr     (ptr_clr),
        .en      (ptr_en),
        .cnt     (ptr),
        .cnt_inc (ptr_inc)
    );

    // A zero delay would make the read alias the same-cycle write.
    assign cfg_delay_eff = (cfg_delay == '0) ? A_WIDTH'(1) : cfg_delay;
    assign cfg_xfer      = cfg_valid && cfg_ready && !stop;
    assign fill_inc      = (fill_cnt == LAST_ADDR) ? LAST_ADDR : fill_cnt + A_WIDTH'(1);
    assign state_o       = state;

    always_comb begin
        state_n = state;
        ptr_clr = 1'b0;
        ptr_en  = 1'b0;
        if (stop) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_n = ST_CLEAR;
                        ptr_clr = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // ptr tracks the address currently on wr_addr.
                    if (ptr == LAST_ADDR) begin
                        state_n = ST_FILL;
                        ptr_clr = 1'b1;
                    end else begin
                        ptr_en = 1'b1;
                    end
                end
                ST_FILL: begin
                    if (sample_en) begin
                        ptr_en = 1'b1;
                        if (fill_inc == delay_q) begin
                            state_n = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (sample_en) begin
                        ptr_en = 1'b1;
                    end
                    if (cfg_xfer) begin
                        state_n = ST_FILL;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fill_cnt  <= '0;
            delay_q   <= RST_DELAY;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_zero   <= 1'b0;
            rd_enable <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            busy      <= (state_n != ST_IDLE);
            cfg_ready <= (state_n == ST_IDLE) || (state_n == ST_RUN);
            wr_enable <= 1'b0;
            wr_zero   <= 1'b0;
            rd_enable <= 1'b0;
            // RAM dout is valid one cycle after the read strobe, unless the
            // line is being stopped underneath it.
            out_valid <= rd_enable && !stop;
            if (!stop) begin
                unique case (state)
                    ST_IDLE: begin
                        if (cfg_xfer) begin
                            delay_q <= cfg_delay_eff;
                        end
                        if (start) begin
                            wr_enable <= 1'b1;
                            wr_zero   <= 1'b1;
                            wr_addr   <= '0;
                        end
                    end
                    ST_CLEAR: begin
                        if (ptr == LAST_ADDR) begin
                            fill_cnt <= '0;
                        end else begin
                            wr_enable <= 1'b1;
                            wr_zero   <= 1'b1;
                            wr_addr   <= ptr_inc;
                        end
                    end
                    ST_FILL: begin
                        if (sample_en) begin
                            wr_enable <= 1'b1;
                            wr_addr   <= ptr;
                            fill_cnt  <= fill_inc;
                        end
                    end
                    ST_RUN: begin
                        if (sample_en) begin
                            wr_enable <= 1'b1;
                            rd_enable <= 1'b1;
                            wr_addr   <= ptr;
                            // Uses the delay in force before any same-cycle update.
                            rd_addr   <= ptr - delay_q;
                        end
                        if (cfg_xfer) begin
                            delay_q  <= cfg_delay_eff;
                            fill_cnt <= '0;
                        end
                    end
                    default: begin
                        fill_cnt <= fill_cnt;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb/tb_delay_line_ctrl.sv - self-checking bench for delay_line_ctrl with RAM model and reference
module tb_delay_line_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int N   = 16;
    localparam int DEF = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sample_en = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [AW-1:0] cfg_delay = '0;
    logic          cfg_ready;
    logic          wr_enable;
    logic [AW-1:0] wr_addr;
    logic          wr_zero;
    logic          rd_enable;
    logic [AW-1:0] rd_addr;
    logic          out_valid;
    logic          busy;
    logic [1:0]    state_o;

    logic [DW-1:0] din_drv = '0;
    logic [DW-1:0] sample_q = '0;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] dout = '0;

    int n_cmp = 0;
    int n_bad = 0;

    delay_line_ctrl #(
        .A_WIDTH       (AW),
        .D_WIDTH       (DW),
        .DEFAULT_DELAY (DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .sample_en (sample_en),
        .cfg_valid (cfg_valid),
        .cfg_delay (cfg_delay),
        .cfg_ready (cfg_ready),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_zero   (wr_zero),
        .rd_enable (rd_enable),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .busy      (busy),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Datapath emulation: sample register plus dual-port RAM with 1-cycle read.
    always @(posedge clk) begin
        if (sample_en) sample_q <= din_drv;
        if (wr_enable) mem[wr_addr] <= wr_zero ? '0 : sample_q;
        if (rd_enable) dout <= mem[rd_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: sample history indexed by write count since the last CLEAR.
    int            m_state, m_delay, m_fill, m_k, m_clr;
    logic [DW-1:0] hist [8192];
    int            pend_v, pend_d;
    int            e_wr_en, e_wr_zero, e_wr_addr, e_rd_en, e_rd_addr, e_ov, e_dout;

    task automatic cyc(input logic i_st, input logic i_sp, input logic i_se,
                       input logic i_cv, input int i_cd, input int i_d, input logic i_rst);
        rst       = i_rst;
        start     = i_st;
        stop      = i_sp;
        sample_en = i_se;
        cfg_valid = i_cv;
        cfg_delay = AW'(i_cd);
        din_drv   = DW'(i_d);
        @(posedge clk);
        e_wr_en = 0; e_wr_zero = 0; e_rd_en = 0; e_ov = 0;
        if (i_rst) begin
            m_state = 0; m_delay = DEF; pend_v = 0;
        end else begin
            e_ov   = (pend_v != 0 && !i_sp) ? 1 : 0;
            e_dout = pend_d;
            pend_v = 0;
            if (i_sp) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0: begin
                        if (i_cv) m_delay = (i_cd == 0) ? 1 : i_cd;
                        if (i_st) begin
                            m_state = 1; m_clr = 0;
                            e_wr_en = 1; e_wr_zero = 1; e_wr_addr = 0;
                        end
                    end
                    1: begin
                        if (m_clr == N - 1) begin
                            m_state = 2; m_k = 0; m_fill = 0;
                        end else begin
                            m_clr++;
                            e_wr_en = 1; e_wr_zero = 1; e_wr_addr = m_clr;
                        end
                    end
                    2: begin
                        if (i_se) begin
                            e_wr_en = 1; e_wr_addr = m_k % N;
                            hist[m_k] = DW'(i_d);
                            m_k++; m_fill++;
                            if (m_fill == m_delay) m_state = 3;
                        end
                    end
                    default: begin
                        if (i_se) begin
                            e_wr_en = 1; e_rd_en = 1;
                            e_wr_addr = m_k % N;
                            e_rd_addr = (((m_k - m_delay) % N) + N) % N;
                            pend_v = 1;
                            pend_d = (m_k >= m_delay) ? int'(hist[m_k - m_delay]) : 0;
                            hist[m_k] = DW'(i_d);
                            m_k++;
                        end
                        if (i_cv) begin
                            m_delay = (i_cd == 0) ? 1 : i_cd;
                            m_fill = 0; m_state = 2;
                        end
                    end
                endcase
            end
        end
        #1;
        chk("state_o", int'(state_o), m_state);
        chk("busy", int'(busy), (m_state != 0) ? 1 : 0);
        chk("cfg_ready", int'(cfg_ready), (m_state == 0 || m_state == 3) ? 1 : 0);
        chk("wr_enable", int'(wr_enable), e_wr_en);
        chk("wr_zero", int'(wr_zero), e_wr_zero);
        if (e_wr_en != 0) chk("wr_addr", int'(wr_addr), e_wr_addr);
        chk("rd_enable", int'(rd_enable), e_rd_en);
        if (e_rd_en != 0) chk("rd_addr", int'(rd_addr), e_rd_addr);
        chk("out_valid", int'(out_valid), e_ov);
        if (e_ov != 0) chk("dout", int'(dout), e_dout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Run cycles (optionally strobing while in FILL and holding a cfg offer)
    // until state_o reaches target; count FILL strobes.
    task automatic run_until(input int target, input logic se_fill, input logic cv,
                             input int cd, output int strobes);
        int guard;
        strobes = 0;
        guard = 0;
        while (int'(state_o) != target && guard < 100) begin
            if (se_fill && state_o == 2'd2) strobes++;
            cyc(0, 0, se_fill && (state_o == 2'd2), cv, cd, $urandom_range(255), 0);
            guard++;
        end
        chk("run_until_reached", int'(state_o), target);
    endtask

    typedef struct {
        logic st, sp, se, cv;
        int   cd, d;
        int   e_state, e_ov, e_dout;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic sp, input logic se, input logic cv,
                                input int cd, input int d, input int es, input int eo, input int ed);
        vec_t v;
        v.st = st; v.sp = sp; v.se = se; v.cv = cv; v.cd = cd; v.d = d;
        v.e_state = es; v.e_ov = eo; v.e_dout = ed;
        return v;
    endfunction

    vec_t tbl [37];

    initial begin
        int s;
        int saw_wrap;
        int prev_rd;
        int strobes;

        // Delay 3 fill/run, then 3 -> 7 change with a same-cycle strobe.
        tbl[0] = mk(1, 0, 0, 1, 3, 0, 1, 0, 0);
        for (int i = 1; i < 16; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 2, 0, 0);
        tbl[17] = mk(0, 0, 1, 0, 0, 8'h10, 2, 0, 0);
        tbl[18] = mk(0, 0, 1, 0, 0, 8'h11, 2, 0, 0);
        tbl[19] = mk(0, 0, 1, 0, 0, 8'h12, 3, 0, 0);
        tbl[20] = mk(0, 0, 1, 0, 0, 8'h13, 3, 0, 0);
        tbl[21] = mk(0, 0, 1, 0, 0, 8'h14, 3, 1, 8'h10);
        tbl[22] = mk(0, 0, 1, 0, 0, 8'h15, 3, 1, 8'h11);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 3, 1, 8'h12);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 3, 0, 0);
        tbl[25] = mk(0, 0, 1, 1, 7, 8'h16, 2, 0, 0);
        tbl[26] = mk(0, 0, 0, 0, 0, 0, 2, 1, 8'h13);
        for (int i = 0; i < 7; i++)
            tbl[27 + i] = mk(0, 0, 1, 0, 0, 8'h17 + i, (i == 6) ? 3 : 2, 0, 0);
        tbl[34] = mk(0, 0, 1, 0, 0, 8'h1E, 3, 0, 0);
        tbl[35] = mk(0, 0, 0, 0, 0, 0, 3, 1, 8'h17);
        tbl[36] = mk(0, 0, 0, 0, 0, 0, 3, 0, 0);

        for (int i = 0; i < N; i++) mem[i] = '0;
        m_state = 0; m_delay = DEF; m_fill = 0; m_k = 0; m_clr = 0; pend_v = 0; pend_d = 0;

        // Reset state
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rst_state", int'(state_o), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);

        // Clear sweep, fill, run, delay change
        for (int i = 0; i < 37; i++) begin
            cyc(tbl[i].st, tbl[i].sp, tbl[i].se, tbl[i].cv, tbl[i].cd, tbl[i].d, 0);
            chk($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].e_state);
            chk($sformatf("tbl%0d_ov", i), int'(out_valid), tbl[i].e_ov);
            if (tbl[i].e_ov != 0) chk($sformatf("tbl%0d_dout", i), int'(dout), tbl[i].e_dout);
        end

        // Max delay on depth 16: read address must wrap 15 -> 0
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 15, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        run_until(2, 0, 0, 0, strobes);
        saw_wrap = 0;
        prev_rd = -1;
        s = 0;
        for (int g = 0; g < 200 && s < 40; g++) begin
            if ($urandom_range(3) != 0) begin
                cyc(0, 0, 1, 0, 0, $urandom_range(255), 0);
                s++;
            end else begin
                cyc(0, 0, 0, 0, 0, 0, 0);
            end
            if (rd_enable) begin
                if (prev_rd == N - 1 && rd_addr == '0) saw_wrap = 1;
                prev_rd = int'(rd_addr);
            end
        end
        idle(2);
        chk("wrap_seen", saw_wrap, 1);

        // cfg_delay 0 loads as 1; stop during FILL
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        run_until(2, 0, 0, 0, strobes);
        cyc(0, 0, 1, 0, 0, 8'hA0, 0);
        chk("delay0_run", int'(state_o), 3);
        cyc(0, 0, 1, 0, 0, 8'hA1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("delay0_ov", int'(out_valid), 1);
        chk("delay0_dout", int'(dout), 8'hA0);
        cyc(0, 0, 0, 1, 5, 0, 0);
        cyc(0, 0, 1, 0, 0, 8'hA2, 0);
        cyc(0, 1, 1, 0, 0, 8'hA3, 0);
        chk("stop_state", int'(state_o), 0);
        chk("stop_wr_en", int'(wr_enable), 0);
        chk("stop_rd_en", int'(rd_enable), 0);
        chk("stop_busy", int'(busy), 0);

        // start ignored in RUN; cfg held through CLEAR/FILL; rst mid-RUN
        cyc(1, 0, 0, 0, 0, 0, 0);
        run_until(2, 0, 0, 0, strobes);
        run_until(3, 1, 0, 0, strobes);
        chk("fill5_strobes", strobes, 5);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("start_in_run", int'(state_o), 3);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        chk("clear_cfg_ready", int'(cfg_ready), 0);
        run_until(2, 0, 1, 2, strobes);
        run_until(3, 1, 1, 2, strobes);
        chk("held_cfg_old_delay", strobes, 5);
        cyc(0, 0, 0, 1, 2, 0, 0);
        chk("held_cfg_accepted", int'(state_o), 2);
        run_until(3, 1, 0, 0, strobes);
        chk("new_delay_strobes", strobes, 2);
        cyc(0, 0, 1, 0, 0, 8'h55, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_state", int'(state_o), 0);
        chk("rst_mid_cfg_ready", int'(cfg_ready), 1);
        chk("rst_mid_ov", int'(out_valid), 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        run_until(2, 0, 0, 0, strobes);
        run_until(3, 1, 0, 0, strobes);
        chk("rst_default_delay", strobes, DEF);

        // Random traffic against the reference
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(19) == 0, $urandom_range(59) == 0, $urandom_range(1) == 0,
                $urandom_range(14) == 0, $urandom_range(N - 1), $urandom_range(255),
                $urandom_range(299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
